// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// Defining PIPE_CTRL_PERF_EN adds the stall/flush performance counter outputs.
interface pipe_hazard_ctrl_if;
    logic       id_rf_valid;
    logic [3:0] id_rf_opcode;
    logic [3:0] id_rf_src1;
    logic [3:0] id_rf_src2;
    logic [8:0] id_rf_imm9;
    logic       rf_ex_valid;
    logic       rf_ex_is_load;
    logic [2:0] rf_ex_dest;
    logic       rf_redirect;
    logic       ex_redirect;

    logic       pc_enable;
    logic       if_id_enable;
    logic       id_rf_enable;
    logic       rf_ex_enable;
    logic       if_id_flush;
    logic       id_rf_flush;
    logic       rf_ex_flush;
    logic       lmsm_active;
    logic [2:0] lmsm_reg;
    logic [2:0] lmsm_offset;
    logic       lmsm_last;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    modport master (
`ifdef PIPE_CTRL_PERF_EN
        input  stall_cycles, flush_events,
`endif
        output id_rf_valid, id_rf_opcode, id_rf_src1, id_rf_src2, id_rf_imm9,
        output rf_ex_valid, rf_ex_is_load, rf_ex_dest, rf_redirect, ex_redirect,
        input  pc_enable, if_id_enable, id_rf_enable, rf_ex_enable,
        input  if_id_flush, id_rf_flush, rf_ex_flush,
        input  lmsm_active, lmsm_reg, lmsm_offset, lmsm_last
    );

    modport slave (
`ifdef PIPE_CTRL_PERF_EN
        output stall_cycles, flush_events,
`endif
        input  id_rf_valid, id_rf_opcode, id_rf_src1, id_rf_src2, id_rf_imm9,
        input  rf_ex_valid, rf_ex_is_load, rf_ex_dest, rf_redirect, ex_redirect,
        output pc_enable, if_id_enable, id_rf_enable, rf_ex_enable,
        output if_id_flush, id_rf_flush, rf_ex_flush,
        output lmsm_active, lmsm_reg, lmsm_offset, lmsm_last
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect squashes, LM/SM micro-op sequencing.
// Outputs are combinational in the same cycle; stalls are expressed as enables; PIPE_CTRL_PERF_EN adds counters.
module pipe_hazard_ctrl #(
    parameter logic [3:0] LM_OPCODE = 4'b0110,
    parameter logic [3:0] SM_OPCODE = 4'b0111
) (
    input  logic              clock,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {S_IDLE = 1'b0, S_SEQ = 1'b1} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_remaining, w_remaining_nxt;
    logic [2:0] r_offset, w_offset_nxt;

    logic [7:0] w_mask, w_mask_rest, w_rem_rest;
    logic       w_src1_hit, w_src2_hit, w_load_use, w_rf_redir;
    logic       w_lmsm_start, w_lmsm_multi;

    function automatic logic [2:0] f_lsb_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign w_mask       = bus.id_rf_imm9[7:0];
    assign w_mask_rest  = w_mask & (w_mask - 8'd1);
    assign w_rem_rest   = r_remaining & (r_remaining - 8'd1);
    assign w_src1_hit   = !bus.id_rf_src1[3] && (bus.id_rf_src1[2:0] == bus.rf_ex_dest);
    assign w_src2_hit   = !bus.id_rf_src2[3] && (bus.id_rf_src2[2:0] == bus.rf_ex_dest);
    assign w_load_use   = bus.id_rf_valid && bus.rf_ex_valid && bus.rf_ex_is_load
                          && (w_src1_hit || w_src2_hit);
    assign w_rf_redir   = bus.rf_redirect && bus.id_rf_valid;
    assign w_lmsm_start = bus.id_rf_valid && (w_mask != 8'd0)
                          && ((bus.id_rf_opcode == LM_OPCODE) || (bus.id_rf_opcode == SM_OPCODE));
    assign w_lmsm_multi = (w_mask_rest != 8'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= 8'd0;
            r_offset    <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_offset    <= w_offset_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_offset_nxt    = r_offset;
        if (reset || bus.ex_redirect) begin
            w_state_nxt     = S_IDLE;
            w_remaining_nxt = 8'd0;
            w_offset_nxt    = 3'd0;
        end else if (r_state == S_SEQ) begin
            // Leaving SEQ once the last remaining bit is issued this cycle
            if (w_rem_rest == 8'd0) begin
                w_state_nxt     = S_IDLE;
                w_remaining_nxt = 8'd0;
                w_offset_nxt    = 3'd0;
            end else begin
                w_remaining_nxt = w_rem_rest;
                w_offset_nxt    = r_offset + 3'd1;
            end
        end else if (!w_load_use && !w_rf_redir && w_lmsm_start && w_lmsm_multi) begin
            w_state_nxt     = S_SEQ;
            w_remaining_nxt = w_mask_rest;
            w_offset_nxt    = 3'd1;
        end
    end

    always_comb begin
        bus.pc_enable    = 1'b1;
        bus.if_id_enable = 1'b1;
        bus.id_rf_enable = 1'b1;
        bus.rf_ex_enable = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_rf_flush  = 1'b0;
        bus.rf_ex_flush  = 1'b0;
        bus.lmsm_active  = 1'b0;
        bus.lmsm_reg     = 3'd0;
        bus.lmsm_offset  = 3'd0;
        bus.lmsm_last    = 1'b0;
        if (reset) begin
            bus.pc_enable    = 1'b0;
            bus.if_id_enable = 1'b0;
            bus.id_rf_enable = 1'b0;
            bus.rf_ex_enable = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_rf_flush  = 1'b1;
            bus.rf_ex_flush  = 1'b1;
        end else if (bus.ex_redirect) begin
            bus.if_id_flush = 1'b1;
            bus.id_rf_flush = 1'b1;
            bus.rf_ex_flush = 1'b1;
        end else if (r_state == S_SEQ) begin
            bus.lmsm_active = 1'b1;
            bus.lmsm_reg    = f_lsb_idx(r_remaining);
            bus.lmsm_offset = r_offset;
            if (w_rem_rest == 8'd0) begin
                bus.lmsm_last = 1'b1;
            end else begin
                bus.pc_enable    = 1'b0;
                bus.if_id_enable = 1'b0;
                bus.id_rf_enable = 1'b0;
            end
        end else if (w_load_use) begin
            // Hold the consumer in ID_RF and push a bubble into RF_EX
            bus.pc_enable    = 1'b0;
            bus.if_id_enable = 1'b0;
            bus.id_rf_enable = 1'b0;
            bus.rf_ex_flush  = 1'b1;
        end else if (w_rf_redir) begin
            bus.if_id_flush = 1'b1;
            bus.id_rf_flush = 1'b1;
        end else if (w_lmsm_start) begin
            bus.lmsm_active = 1'b1;
            bus.lmsm_reg    = f_lsb_idx(w_mask);
            if (!w_lmsm_multi) begin
                bus.lmsm_last = 1'b1;
            end else begin
                bus.pc_enable    = 1'b0;
                bus.if_id_enable = 1'b0;
                bus.id_rf_enable = 1'b0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_stall_cycles, r_flush_events;
    logic        w_flush_taken;

    assign w_flush_taken = bus.ex_redirect
                           || ((r_state == S_IDLE) && !w_load_use && w_rf_redir);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
            r_flush_events <= 16'd0;
        end else begin
            if (!bus.pc_enable && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_flush_taken && (r_flush_events != 16'hFFFF))
                r_flush_events <= r_flush_events + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized run against a queue-based model.
module tb_pipe_hazard_ctrl;
    localparam logic [3:0] LM  = 4'b0110;
    localparam logic [3:0] SM  = 4'b0111;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] EN_ALL = 4'b1111, EN_STALL = 4'b0001, EN_NONE = 4'b0000;
    localparam logic [2:0] FL_ALL = 3'b111, FL_NONE = 3'b000, FL_BUB = 3'b001, FL_RFR = 3'b110;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [14:0] got, exp;

    pipe_hazard_ctrl_if bus();
    pipe_hazard_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    function automatic logic [14:0] obs();
        return {bus.pc_enable, bus.if_id_enable, bus.id_rf_enable, bus.rf_ex_enable,
                bus.if_id_flush, bus.id_rf_flush, bus.rf_ex_flush,
                bus.lmsm_active, bus.lmsm_reg, bus.lmsm_offset, bus.lmsm_last};
    endfunction

    function automatic logic [14:0] mk(input logic [3:0] en, input logic [2:0] fl, input logic act,
                                       input logic [2:0] r, input logic [2:0] o, input logic last);
        return {en, fl, act, r, o, last};
    endfunction

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1 time unit later
    task automatic drive(input logic rst, input logic idv, input logic [3:0] op,
                         input logic [3:0] s1, input logic [3:0] s2, input logic [8:0] imm,
                         input logic exv, input logic exld, input logic [2:0] dst,
                         input logic rfr, input logic exr);
        @(negedge clock);
        reset             = rst;
        bus.id_rf_valid   = idv;
        bus.id_rf_opcode  = op;
        bus.id_rf_src1    = s1;
        bus.id_rf_src2    = s2;
        bus.id_rf_imm9    = imm;
        bus.rf_ex_valid   = exv;
        bus.rf_ex_is_load = exld;
        bus.rf_ex_dest    = dst;
        bus.rf_redirect   = rfr;
        bus.ex_redirect   = exr;
        #1;
        got = obs();
    endtask

    task automatic test_reset();
        drive(1, 0, ADD, 4'h8, 4'h8, 9'h000, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_NONE, FL_ALL, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL reset_c1 got=%h want=%h", got, exp); end
        drive(1, 1, LM, 4'h2, 4'h8, 9'h00F, 1, 1, 3'd2, 1, 1);
        total++;
        if (got !== exp) begin bad++; $display("FAIL reset_c2_priority got=%h want=%h", got, exp); end
        drive(0, 0, ADD, 4'h8, 4'h8, 9'h000, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL reset_release got=%h want=%h", got, exp); end
    endtask

    task automatic test_load_use();
        logic [2:0] d;
        logic [2:0] e;
        d = 3'($urandom_range(0, 7));
        e = d + 3'd1;
        drive(0, 1, ADD, {1'b0, d}, 4'h8, 9'h000, 1, 1, d, 0, 0);
        exp = mk(EN_STALL, FL_BUB, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL lu_src1_bubble got=%h want=%h", got, exp); end
        drive(0, 1, ADD, {1'b0, d}, 4'h8, 9'h000, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL lu_advance got=%h want=%h", got, exp); end
        drive(0, 1, ADD, {1'b1, d}, 4'h8, 9'h000, 1, 1, d, 0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL lu_unused_src got=%h want=%h", got, exp); end
        drive(0, 1, ADD, {1'b0, e}, {1'b0, d}, 9'h000, 1, 1, d, 0, 0);
        exp = mk(EN_STALL, FL_BUB, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL lu_src2 got=%h want=%h", got, exp); end
        drive(0, 1, ADD, {1'b0, d}, 4'h8, 9'h000, 1, 0, d, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL lu_not_load got=%h want=%h", got, exp); end
        drive(0, 0, ADD, {1'b0, d}, 4'h8, 9'h000, 1, 1, d, 0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL lu_id_invalid got=%h want=%h", got, exp); end
    endtask

    task automatic test_lmsm();
        logic [2:0] d;
        int lows;
        d = 3'($urandom_range(0, 7));
        lows = 0;
        drive(0, 1, LM, 4'h8, 4'h8, 9'h0A4, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_STALL, FL_NONE, 1, 3'd2, 3'd0, 0); total++;
        if (!got[14]) lows++;
        if (got !== exp) begin bad++; $display("FAIL lm_uop0 got=%h want=%h", got, exp); end
        drive(0, 1, LM, {1'b0, d}, 4'h8, 9'h0A4, 1, 1, d, 1, 0);
        exp = mk(EN_STALL, FL_NONE, 1, 3'd5, 3'd1, 0); total++;
        if (!got[14]) lows++;
        if (got !== exp) begin bad++; $display("FAIL lm_uop1 got=%h want=%h", got, exp); end
        drive(0, 1, LM, {1'b0, d}, 4'h8, 9'h0A4, 1, 1, d, 1, 0);
        exp = mk(EN_ALL, FL_NONE, 1, 3'd7, 3'd2, 1); total++;
        if (!got[14]) lows++;
        if (got !== exp) begin bad++; $display("FAIL lm_uop2_last got=%h want=%h", got, exp); end
        drive(0, 0, ADD, 4'h8, 4'h8, 9'h000, 1, 1, 3'd7, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (!got[14]) lows++;
        if (got !== exp) begin bad++; $display("FAIL lm_after got=%h want=%h", got, exp); end
        total++;
        if (lows != 2) begin bad++; $display("FAIL lm_stall_count got=%0d want=2", lows); end
    endtask

    task automatic test_sm_single();
        logic [2:0] k;
        logic [8:0] m;
        drive(0, 1, SM, 4'h8, 4'h8, 9'h001, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 1, 3'd0, 3'd0, 1); total++;
        if (got !== exp) begin bad++; $display("FAIL sm_mask01 got=%h want=%h", got, exp); end
        drive(0, 1, SM, 4'h8, 4'h8, 9'h100, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL sm_mask00 got=%h want=%h", got, exp); end
        k = 3'($urandom_range(0, 7));
        m = 9'd1 << k;
        drive(0, 1, LM, 4'h8, 4'h8, m, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 1, k, 3'd0, 1); total++;
        if (got !== exp) begin bad++; $display("FAIL lm_single_bit got=%h want=%h", got, exp); end
    endtask

    task automatic test_redirect_priority();
        logic [2:0] d;
        d = 3'($urandom_range(0, 7));
        drive(0, 1, ADD, {1'b0, d}, 4'h8, 9'h000, 1, 1, d, 0, 1);
        exp = mk(EN_ALL, FL_ALL, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL exr_over_lu got=%h want=%h", got, exp); end
        drive(0, 1, ADD, 4'h8, 4'h8, 9'h000, 0, 0, 3'd0, 1, 0);
        exp = mk(EN_ALL, FL_RFR, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL rfr_alone got=%h want=%h", got, exp); end
        drive(0, 0, ADD, 4'h8, 4'h8, 9'h000, 0, 0, 3'd0, 1, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL rfr_invalid got=%h want=%h", got, exp); end
        drive(0, 1, ADD, {1'b0, d}, 4'h8, 9'h000, 1, 1, d, 1, 0);
        exp = mk(EN_STALL, FL_BUB, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL lu_over_rfr got=%h want=%h", got, exp); end
        drive(0, 1, LM, 4'h8, 4'h8, 9'h0FF, 0, 0, 3'd0, 1, 0);
        exp = mk(EN_ALL, FL_RFR, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL rfr_over_lm got=%h want=%h", got, exp); end
        drive(0, 0, ADD, 4'h8, 4'h8, 9'h000, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL rfr_no_seq got=%h want=%h", got, exp); end
        drive(0, 1, SM, 4'h8, 4'h8, 9'h0F0, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_STALL, FL_NONE, 1, 3'd4, 3'd0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL sm_f0_start got=%h want=%h", got, exp); end
        drive(0, 1, SM, 4'h8, 4'h8, 9'h0F0, 1, 0, 3'd0, 0, 1);
        exp = mk(EN_ALL, FL_ALL, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL exr_in_seq got=%h want=%h", got, exp); end
        drive(0, 0, ADD, 4'h8, 4'h8, 9'h000, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL exr_seq_abandoned got=%h want=%h", got, exp); end
    endtask

    task automatic test_reset_mid_seq();
        drive(0, 1, LM, 4'h8, 4'h8, 9'h0FF, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_STALL, FL_NONE, 1, 3'd0, 3'd0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL rms_start got=%h want=%h", got, exp); end
        drive(1, 1, LM, 4'h8, 4'h8, 9'h0FF, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_NONE, FL_ALL, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL rms_reset got=%h want=%h", got, exp); end
        drive(0, 1, LM, 4'h8, 4'h8, 9'h003, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_STALL, FL_NONE, 1, 3'd0, 3'd0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL rms_new_uop0 got=%h want=%h", got, exp); end
        drive(0, 1, LM, 4'h8, 4'h8, 9'h003, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 1, 3'd1, 3'd1, 1); total++;
        if (got !== exp) begin bad++; $display("FAIL rms_new_uop1 got=%h want=%h", got, exp); end
        drive(0, 0, ADD, 4'h8, 4'h8, 9'h000, 0, 0, 3'd0, 0, 0);
        exp = mk(EN_ALL, FL_NONE, 0, 0, 0, 0); total++;
        if (got !== exp) begin bad++; $display("FAIL rms_after got=%h want=%h", got, exp); end
    endtask

    // Model: pending micro-ops are a queue; an LM/SM expands its mask into that queue
    task automatic test_random();
        int q_reg[$];
        int q_off[$];
        int stall_exp, flush_exp;
        logic rst, idv, exv, exld, rfr, exr, act, last;
        logic [3:0] op, s1, s2, en;
        logic [2:0] dst, fl, r, o;
        logic [7:0] mask;
        stall_exp = 0;
        flush_exp = 0;
        for (int i = 0; i < 600; i++) begin
            rst  = (i == 0) || ($urandom_range(0, 39) == 0);
            idv  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       op = LM;
                1:       op = SM;
                default: op = 4'($urandom_range(0, 15));
            endcase
            s1   = 4'($urandom_range(0, 15));
            s2   = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       mask = 8'h00;
                1:       mask = 8'h01 << $urandom_range(0, 7);
                default: mask = 8'($urandom_range(0, 255));
            endcase
            exv  = ($urandom_range(0, 3) != 0);
            exld = ($urandom_range(0, 1) != 0);
            dst  = ($urandom_range(0, 1) != 0) ? s1[2:0] : 3'($urandom_range(0, 7));
            rfr  = ($urandom_range(0, 5) == 0);
            exr  = ($urandom_range(0, 9) == 0);

            en = EN_ALL; fl = FL_NONE; act = 1'b0; r = 3'd0; o = 3'd0; last = 1'b0;
            if (rst) begin
                en = EN_NONE; fl = FL_ALL;
                q_reg.delete(); q_off.delete();
            end else if (exr) begin
                fl = FL_ALL; flush_exp++;
                q_reg.delete(); q_off.delete();
            end else if (q_reg.size() > 0) begin
                act = 1'b1;
                r = 3'(q_reg.pop_front());
                o = 3'(q_off.pop_front());
                last = (q_reg.size() == 0);
                if (!last) en = EN_STALL;
            end else if (idv && exv && exld && ((!s1[3] && s1[2:0] == dst) || (!s2[3] && s2[2:0] == dst))) begin
                en = EN_STALL; fl = FL_BUB;
            end else if (rfr && idv) begin
                fl = FL_RFR; flush_exp++;
            end else if (idv && (op == LM || op == SM) && mask != 8'h00) begin
                int n;
                n = 0;
                for (int b = 0; b < 8; b++) begin
                    if (mask[b]) begin
                        if (n == 0) r = 3'(b);
                        else begin q_reg.push_back(b); q_off.push_back(n); end
                        n++;
                    end
                end
                act = 1'b1; last = (n == 1);
                if (!last) en = EN_STALL;
            end
            if (rst) begin stall_exp = 0; flush_exp = 0; end
            else if (!en[3]) stall_exp++;

            drive(rst, idv, op, s1, s2, {1'($urandom_range(0, 1)), mask}, exv, exld, dst, rfr, exr);
            exp = mk(en, fl, act, r, o, last); total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rand_cycle%0d got=%h want=%h", i, got, exp);
            end
        end
`ifdef PIPE_CTRL_PERF_EN
        @(negedge clock);
        total++;
        if (bus.stall_cycles !== 16'(stall_exp)) begin
            bad++; $display("FAIL perf_stall got=%0d want=%0d", bus.stall_cycles, stall_exp);
        end
        total++;
        if (bus.flush_events !== 16'(flush_exp)) begin
            bad++; $display("FAIL perf_flush got=%0d want=%0d", bus.flush_events, flush_exp);
        end
`endif
    endtask

    initial begin
        bus.id_rf_valid   = 1'b0;
        bus.id_rf_opcode  = ADD;
        bus.id_rf_src1    = 4'h8;
        bus.id_rf_src2    = 4'h8;
        bus.id_rf_imm9    = 9'h000;
        bus.rf_ex_valid   = 1'b0;
        bus.rf_ex_is_load = 1'b0;
        bus.rf_ex_dest    = 3'd0;
        bus.rf_redirect   = 1'b0;
        bus.ex_redirect   = 1'b0;
        test_reset();
        test_load_use();
        test_lmsm();
        test_sm_single();
        test_redirect_priority();
        test_reset_mid_seq();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
